// File: rtl/alu74181_pkg.sv
// rtl/alu74181_pkg.sv - shared 74181 function-select, mode constants and sequencer state enum
package alu74181_pkg;

  // 74181 function-select codes, active-high data convention
  localparam logic [3:0] ALU_S_ADD = 4'b1001;  // with M=0: F = A plus B plus carry
  localparam logic [3:0] ALU_S_SUB = 4'b0110;  // with M=0: F = A minus B minus 1 plus carry
  localparam logic [3:0] ALU_S_XOR = 4'b0110;  // with M=1: F = A xor B

  // Mode select
  localparam logic ALU_M_LOGIC = 1'b1;
  localparam logic ALU_M_ARITH = 1'b0;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - nibble-serial sequencer for one external 74181 slice (optional ALU_SEQ_OVERFLOW_EN adds ovf)
module alu_nibble_sequencer
  import alu74181_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [3:0]       slice_s,
  output logic             slice_m,
  output logic             slice_ci,
  input  logic [3:0]       slice_f,
  input  logic             slice_co,
  input  logic             slice_aeqb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             aeqb_all
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // operand A, shifted right one nibble per pass
  logic [WIDTH-1:0] b_q, b_d;        // operand B, shifted right one nibble per pass
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d; // active-low ripple carry, same polarity as the slice
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             aeqb_q, aeqb_d;   // AND of slice A=B across the nibbles seen so far
  logic             zero_q, zero_d;

`ifdef ALU_SEQ_OVERFLOW_EN
  // Operand sign bits are kept apart because the shift registers lose them after the first pass
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state, shift-register and result-assembly logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    aeqb_d   = aeqb_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          carry_d = ~op_cin;
          idx_d   = '0;
          aeqb_d  = 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = op_b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        result_d[int'(idx_q)*4 +: 4] = slice_f;
        carry_d = slice_co;
        aeqb_d  = aeqb_q & slice_aeqb;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIB - 1)) begin
          // Last nibble: flags are frozen here so they stay put for the whole DONE phase
          zero_d  = (result_d == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf_d = 1'b0;
          if (m_q == ALU_M_ARITH && s_q == ALU_S_ADD)
            ovf_d = (a_msb_q == b_msb_q) && (result_d[WIDTH-1] != a_msb_q);
          else if (m_q == ALU_M_ARITH && s_q == ALU_S_SUB)
            ovf_d = (a_msb_q != b_msb_q) && (result_d[WIDTH-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b1;
      idx_q    <= '0;
      result_q <= '0;
      aeqb_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      aeqb_q   <= aeqb_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Slice drive and handshake outputs; the slice sees idle values outside RUN
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_s   = 4'h0;
    slice_m   = 1'b0;
    slice_ci  = 1'b1;
    if (state_q == RUN) begin
      slice_a  = a_q[3:0];
      slice_b  = b_q[3:0];
      slice_s  = s_q;
      slice_m  = m_q;
      slice_ci = carry_q;
    end
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    cout      = (m_q == ALU_M_ARITH) & ~carry_q;
    zero      = zero_q;
    aeqb_all  = aeqb_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - scoreboard bench with a behavioural 74181 slice (honours ALU_SEQ_OVERFLOW_EN)
module tb_alu_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_s;
  logic        op_m, op_cin;
  logic [3:0]  slice_a, slice_b, slice_s;
  logic        slice_m, slice_ci;
  logic [3:0]  slice_f;
  logic        slice_co, slice_aeqb;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        cout, zero, aeqb_all;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic        ovf;
`endif

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        aeqb;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_m(slice_m), .slice_ci(slice_ci),
    .slice_f(slice_f), .slice_co(slice_co), .slice_aeqb(slice_aeqb),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .aeqb_all(aeqb_all)
`ifdef ALU_SEQ_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  // Behavioural 74181 slice: active-high data, active-low Cn and Cn+4
  logic [4:0] sum;
  logic [3:0] lf;
  always_comb begin
    sum = {4'b0, ~slice_ci} + {1'b0, slice_a};
    case (slice_s)
      4'b1001: sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, ~slice_ci};
      4'b0110: sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'b0, ~slice_ci};
      default: ;
    endcase
    case (slice_s)
      4'h0: lf = ~slice_a;
      4'h1: lf = ~(slice_a | slice_b);
      4'h2: lf = ~slice_a & slice_b;
      4'h3: lf = 4'h0;
      4'h4: lf = ~(slice_a & slice_b);
      4'h5: lf = ~slice_b;
      4'h6: lf = slice_a ^ slice_b;
      4'h7: lf = slice_a & ~slice_b;
      4'h8: lf = ~slice_a | slice_b;
      4'h9: lf = ~(slice_a ^ slice_b);
      4'hA: lf = slice_b;
      4'hB: lf = slice_a & slice_b;
      4'hC: lf = 4'hF;
      4'hD: lf = slice_a | ~slice_b;
      4'hE: lf = slice_a | slice_b;
      default: lf = slice_a;
    endcase
    slice_f    = slice_m ? lf : sum[3:0];
    slice_co   = slice_m ? 1'b1 : ~sum[4];
    slice_aeqb = (slice_f == 4'hF);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: compares each accepted result against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {16'h0, result}, {16'h0, e.res});
          check("cout", {31'b0, cout}, {31'b0, e.cout});
          check("zero", {31'b0, zero}, {31'b0, e.zero});
          check("aeqb_all", {31'b0, aeqb_all}, {31'b0, e.aeqb});
`ifdef ALU_SEQ_OVERFLOW_EN
          check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
        end
      end
    end
  end

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin);
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input exp_t e, input int hold);
    int n;
    exp_q.push_back(e);
    out_ready = (hold == 0);
    accept(a, b, s, m, cin);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, 32'd4);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", {16'h0, result}, {16'h0, e.res});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", {16'h0, result}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_aeqb_all", {31'b0, aeqb_all}, 32'd0);
    check("rst_slice_abs", {20'h0, slice_a, slice_b, slice_s}, 32'd0);
    check("rst_slice_m", {31'b0, slice_m}, 32'd0);
    check("rst_slice_ci", {31'b0, slice_ci}, 32'd1);

    // res, cout, zero, aeqb, ovf
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}, 0);
    run_op(16'h5000, 16'h5000, 4'b0110, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}, 0);
    run_op(16'h5000, 16'h5000, 4'b0110, 1'b0, 1'b0, '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
    run_op(16'hF0F0, 16'h00FF, 4'b0110, 1'b1, 1'b0, '{16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0}, 3);

    // Reset after two nibble captures discards the operation
    out_ready = 1'b1;
    accept(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_result", {16'h0, result}, 32'd0);
    check("midrst_slice_ci", {31'b0, slice_ci}, 32'd1);

    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
    run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b1}, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Sequences a WIDTH-bit ALU operation through one external 4-bit 74181-style slice, one nibble per clock, LS nibble first.
- Upstream: accepts operands and the function code over a valid/ready handshake, then drives the slice inputs from shift registers.
- Downstream: captures the slice's F, Co and AeqB outputs, ripples the carry through a register, and presents the assembled result and flags over valid/ready.
- Sits between the operand/decode stage and the 74181 slice.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- NIB, WIDTH/4, number of nibble passes (derived; not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_s  in  4  74181 function select.
- op_m  in  1  mode: 1 = logic, 0 = arithmetic.
- op_cin  in  1  carry in, active-high.
- slice_a  out  4  nibble of A driven to the slice.
- slice_b  out  4  nibble of B driven to the slice.
- slice_s  out  4  function select driven to the slice.
- slice_m  out  1  mode driven to the slice.
- slice_ci  out  1  slice carry in, active-low (Cn).
- slice_f  in  4  slice function output.
- slice_co  in  1  slice carry out, active-low (Cn+4).
- slice_aeqb  in  1  slice A=B output.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  assembled F.
- cout  out  1  final carry, active-high; forced 0 when M=1.
- zero  out  1  result == 0.
- aeqb_all  out  1  AND of slice_aeqb over all nibbles.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1 after the reset edge, out_valid=0, result/cout/zero/aeqb_all=0, slice_a/b/s=0, slice_m=0, slice_ci=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge T: latch A, B, S and M; load carry register = ~op_cin; idx=0; go to RUN.
- RUN:
  - slice_* are driven combinationally from the registers: nibble idx of A/B, latched S/M, slice_ci = carry register.
  - Each edge: result[4*idx+:4] <= slice_f; carry register <= slice_co; aeqb accumulator &= slice_aeqb; idx++.
  - After the capture with idx == NIB-1, go to DONE.
  - The slice is purely combinational; no wait states.
- Latency: out_valid rises after edge T+NIB (4 cycles at default WIDTH).
- DONE:
  - out_valid=1; result and flags are held stable while out_ready=0.
  - cout = ~carry register if M==0, else 0. zero = (result==0). aeqb_all = accumulator.
  - When out_valid && out_ready at an edge: go to IDLE; in_ready=1 from the next cycle. No same-cycle turnaround.
- in_ready=0 in RUN and DONE. in_valid is ignored outside IDLE.
- Reset mid-RUN or mid-DONE: the operation is discarded; the reset values above apply at the next edge.
- Logic mode (M=1): the carry still ripples but is ignored by the slice; cout reported as 0.
- The carry register is the only inter-nibble link; CP/CG lookahead is unused.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- Defined: adds output ovf (1 bit), registered and valid with out_valid.
  - For M=0, S=1001 (add): ovf = (a_msb==b_msb) && (r_msb!=a_msb).
  - For M=0, S=0110 (subtract): ovf = (a_msb!=b_msb) && (r_msb!=a_msb).
  - Otherwise ovf=0. Reset value 0.
- Undefined: no ovf port and no related logic.

Decomposition:
- Shared package alu74181_pkg holds:
  - function-select constants ALU_S_ADD=4'b1001, ALU_S_SUB=4'b0110, ALU_S_XOR=4'b0110 (with M=1);
  - mode constants ALU_M_LOGIC=1, ALU_M_ARITH=0;
  - the FSM state enum.
- No sub-module: the 74181 slice is instantiated beside this block by the parent, not inside it.

Test Plan:
- Add, no carry out: M=0, S=1001, A=0x1234, B=0x0FFF, cin=0 -> result=0x2233, cout=0, zero=0; out_valid exactly 4 cycles after accept.
- Add, full wrap: A=0xFFFF, B=0x0001, cin=0 -> result=0x0000, cout=1, zero=1; with ALU_SEQ_OVERFLOW_EN, ovf=0.
- Subtract and A=B detection:
  - S=0110, M=0, A=B=0x5000, cin=1 -> result=0x0000, cout=1.
  - Same operands with cin=0 -> result=0xFFFF, aeqb_all=1.
- Logic and backpressure: M=1, S=0110, A=0xF0F0, B=0x00FF -> result=0xF00F, cout=0. Hold out_ready=0 for 3 cycles -> result stable, in_ready=0; in_ready=1 the cycle after acceptance.
- Reset mid-RUN: assert rst after 2 nibbles -> next cycle out_valid=0, in_ready=1, result=0, slice_ci=1. A following operation completes correctly.
- Signed overflow (ALU_SEQ_OVERFLOW_EN defined): A=0x7FFF, B=0x0001, add -> result=0x8000, ovf=1.
